// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: execute-stage request, SRAM port and register-file write port.
// slave = the access unit, master = the surrounding core/memory environment.
interface mem_access_unit_if #(
    parameter int AW  = 10,
    parameter int RAW = 5
);
    // Request handshake: a request transfers on a rising edge where REQ_VALID & REQ_READY;
    // fields must be held stable while REQ_VALID is high and REQ_READY is low.
    logic            REQ_VALID;
    logic            REQ_READY;
    logic            REQ_WE;
    logic [1:0]      REQ_SIZE;
    logic            REQ_UNSIGNED;
    logic [AW+1:0]   REQ_ADDR;
    logic [31:0]     REQ_WDATA;
    logic [RAW-1:0]  REQ_RD;

    logic            MEM_CSN;
    logic            MEM_WEN;
    logic [AW-1:0]   MEM_A;
    logic [31:0]     MEM_DI;
    logic [31:0]     MEM_DOUT;

    logic            RF_WEN;
    logic [RAW-1:0]  RF_WA;
    logic [31:0]     RF_DI;

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, REQ_RD,
        output REQ_READY,
        output MEM_CSN, MEM_WEN, MEM_A, MEM_DI,
        input  MEM_DOUT,
        output RF_WEN, RF_WA, RF_DI
    );

    modport master (
        output REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, REQ_RD,
        input  REQ_READY,
        input  MEM_CSN, MEM_WEN, MEM_A, MEM_DI,
        output MEM_DOUT,
        input  RF_WEN, RF_WA, RF_DI
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access stage: loads with sign/zero extension, byte/half stores via read-modify-write.
// Optional feature macro: MAU_R0_GUARD_EN suppresses register-file writes for loads to r0.
module mem_access_unit #(
    parameter int AW  = 10,
    parameter int RAW = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_access_unit_if.slave     bus,
    output logic                 ERR,
    output logic                 BUSY,
    output logic [2:0]           DBG_STATE
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD       = 3'd1;
    localparam logic [2:0] RWAIT    = 3'd2;
    localparam logic [2:0] WR       = 3'd3;
    localparam logic [2:0] RMW_RD   = 3'd4;
    localparam logic [2:0] RMW_WAIT = 3'd5;
    localparam logic [2:0] RMW_WR   = 3'd6;

    logic [2:0]     state;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic [RAW-1:0] rd_q;
    logic           err_q;
    logic           rf_wen_q;
    logic [RAW-1:0] rf_wa_q;
    logic [31:0]    rf_di_q;

    logic           accept;
    logic           bad;
    logic           rf_we_ok;
    logic           mem_act;
    logic [31:0]    shifted;
    logic [31:0]    load_val;
    logic [31:0]    merged;

    assign bus.REQ_READY = (state == IDLE) & ~RST;
    assign accept        = bus.REQ_VALID & bus.REQ_READY;

    always_comb begin
        bad = 1'b0;
        case (bus.REQ_SIZE)
            2'b01:   bad = bus.REQ_ADDR[0];
            2'b10:   bad = (bus.REQ_ADDR[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

`ifdef MAU_R0_GUARD_EN
    assign rf_we_ok = (rd_q != '0);
`else
    assign rf_we_ok = 1'b1;
`endif

    // Halfword loads are always aligned, so the byte-lane shift also serves them.
    always_comb begin
        shifted  = bus.MEM_DOUT >> {addr_q[1:0], 3'b000};
        load_val = bus.MEM_DOUT;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = bus.MEM_DOUT;
        endcase
    end

    always_comb begin
        merged = rdata_q;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            size_q   <= '0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            rf_wen_q <= 1'b1;
            rf_wa_q  <= '0;
            rf_di_q  <= '0;
        end else begin
            err_q    <= 1'b0;
            rf_wen_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q  <= bus.REQ_SIZE;
                        uns_q   <= bus.REQ_UNSIGNED;
                        addr_q  <= bus.REQ_ADDR;
                        wdata_q <= bus.REQ_WDATA;
                        rd_q    <= bus.REQ_RD;
                        if (bad)
                            err_q <= 1'b1;
                        else if (!bus.REQ_WE)
                            state <= RD;
                        else if (bus.REQ_SIZE == 2'b10)
                            state <= WR;
                        else
                            state <= RMW_RD;
                    end
                end
                RD:    state <= RWAIT;
                RWAIT: begin
                    state    <= IDLE;
                    rf_di_q  <= load_val;
                    rf_wa_q  <= rd_q;
                    rf_wen_q <= ~rf_we_ok;
                end
                WR:       state <= IDLE;
                RMW_RD:   state <= RMW_WAIT;
                RMW_WAIT: begin
                    rdata_q <= bus.MEM_DOUT;
                    state   <= RMW_WR;
                end
                RMW_WR:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Gating with RST keeps the SRAM deselected on a reset edge that interrupts a write state.
    always_comb begin
        mem_act = ~RST & ((state == RD) | (state == WR) | (state == RMW_RD) | (state == RMW_WR));
        bus.MEM_CSN = ~mem_act;
        bus.MEM_WEN = ~(mem_act & ((state == WR) | (state == RMW_WR)));
        bus.MEM_A   = mem_act ? addr_q[AW+1:2] : '0;
        bus.MEM_DI  = '0;
        if (mem_act && state == WR)
            bus.MEM_DI = wdata_q;
        else if (mem_act && state == RMW_WR)
            bus.MEM_DI = merged;
    end

    assign bus.RF_WEN = rf_wen_q;
    assign bus.RF_WA  = rf_wa_q;
    assign bus.RF_DI  = rf_di_q;
    assign ERR        = err_q;
    assign BUSY       = (state != IDLE);
    assign DBG_STATE  = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural single-port synchronous SRAM.
// Expected values are hand-computed constants.
module tb_mem_access_unit;
    localparam int AW  = 10;
    localparam int RAW = 5;

    logic       CLK;
    logic       RST;
    logic       ERR;
    logic       BUSY;
    logic [2:0] DBG_STATE;
    int         checks = 0;
    int         errors = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    mem_access_unit_if #(.AW(AW), .RAW(RAW)) bus ();

    mem_access_unit #(.AW(AW), .RAW(RAW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .ERR       (ERR),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!bus.MEM_CSN) begin
            if (!bus.MEM_WEN)
                mem[bus.MEM_A] <= bus.MEM_DI;
            else
                bus.MEM_DOUT <= mem[bus.MEM_A];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at E0+1 (one time unit after the accepting edge).
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus.REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_before_req", {31'b0, bus.REQ_READY}, 32'd1);
        bus.REQ_WE       = we;
        bus.REQ_SIZE     = size;
        bus.REQ_UNSIGNED = uns;
        bus.REQ_ADDR     = addr;
        bus.REQ_WDATA    = wdata;
        bus.REQ_RD       = rd;
        bus.REQ_VALID    = 1'b1;
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic st_word(input logic [11:0] addr, input logic [31:0] data);
        send(1'b1, 2'b10, 1'b0, addr, data, 5'd0);
        chk("stw_csn", {31'b0, bus.MEM_CSN}, 32'd0);
        chk("stw_wen", {31'b0, bus.MEM_WEN}, 32'd0);
        chk("stw_di", bus.MEM_DI, data);
        tick();
        chk("stw_busy_after", {31'b0, BUSY}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [4:0] rd, input logic [31:0] exp);
        send(1'b0, size, uns, addr, 32'd0, rd);
        tick();
        tick();
        chk({tag, "_rf_wen"}, {31'b0, bus.RF_WEN}, 32'd0);
        chk({tag, "_rf_wa"}, {27'b0, bus.RF_WA}, {27'b0, rd});
        chk({tag, "_rf_di"}, bus.RF_DI, exp);
        tick();
        chk({tag, "_rf_wen_pulse"}, {31'b0, bus.RF_WEN}, 32'd1);
    endtask

    initial begin
        int lows;
        logic [4:0] wa_low;

        RST = 1'b1;
        bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_SIZE = 2'b00; bus.REQ_UNSIGNED = 1'b0;
        bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.REQ_RD = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready_low", {31'b0, bus.REQ_READY}, 32'd0);
        chk("rst_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        RST = 1'b0;
        #1;
        chk("rst_state", {29'b0, DBG_STATE}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_err", {31'b0, ERR}, 32'd0);
        chk("rst_rf_wen", {31'b0, bus.RF_WEN}, 32'd1);
        chk("rst_rf_wa", {27'b0, bus.RF_WA}, 32'd0);
        chk("rst_rf_di", bus.RF_DI, 32'd0);
        chk("rst_mem_wen", {31'b0, bus.MEM_WEN}, 32'd1);
        chk("rst_mem_a", {22'b0, bus.MEM_A}, 32'd0);
        chk("rst_mem_di", bus.MEM_DI, 32'd0);
        chk("rst_ready_high", {31'b0, bus.REQ_READY}, 32'd1);

        // Word store then detailed word load timing.
        st_word(12'h010, 32'h8765_4321);
        chk("stw_mem4", mem[4], 32'h8765_4321);

        send(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 5'd3);
        chk("ldw_rd_csn", {31'b0, bus.MEM_CSN}, 32'd0);
        chk("ldw_rd_wen", {31'b0, bus.MEM_WEN}, 32'd1);
        chk("ldw_rd_a", {22'b0, bus.MEM_A}, 32'd4);
        chk("ldw_busy", {31'b0, BUSY}, 32'd1);
        chk("ldw_ready_busy", {31'b0, bus.REQ_READY}, 32'd0);
        tick();
        chk("ldw_rwait_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        chk("ldw_rwait_rf_wen", {31'b0, bus.RF_WEN}, 32'd1);
        tick();
        chk("ldw_rf_wen", {31'b0, bus.RF_WEN}, 32'd0);
        chk("ldw_rf_wa", {27'b0, bus.RF_WA}, 32'd3);
        chk("ldw_rf_di", bus.RF_DI, 32'h8765_4321);
        chk("ldw_ready_e2", {31'b0, bus.REQ_READY}, 32'd1);
        tick();
        chk("ldw_rf_wen_pulse", {31'b0, bus.RF_WEN}, 32'd1);

        do_load("ldb_s13", 2'b00, 1'b0, 12'h013, 5'd5, 32'hFFFF_FF87);
        do_load("ldb_u13", 2'b00, 1'b1, 12'h013, 5'd6, 32'h0000_0087);
        do_load("ldh_u12", 2'b01, 1'b1, 12'h012, 5'd7, 32'h0000_8765);
        do_load("ldh_s12", 2'b01, 1'b0, 12'h012, 5'd7, 32'hFFFF_8765);
        do_load("ldh_s10", 2'b01, 1'b0, 12'h010, 5'd8, 32'h0000_4321);
        do_load("ldb_s11", 2'b00, 1'b0, 12'h011, 5'd8, 32'h0000_0043);

        // Byte store via read-modify-write.
        st_word(12'h010, 32'h1122_3344);
        send(1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFF_FFAB, 5'd0);
        chk("stb_rmwrd_csn", {31'b0, bus.MEM_CSN}, 32'd0);
        chk("stb_rmwrd_wen", {31'b0, bus.MEM_WEN}, 32'd1);
        chk("stb_busy_e0", {31'b0, BUSY}, 32'd1);
        tick();
        chk("stb_wait_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        chk("stb_busy_e1", {31'b0, BUSY}, 32'd1);
        tick();
        chk("stb_wr_csn", {31'b0, bus.MEM_CSN}, 32'd0);
        chk("stb_wr_wen", {31'b0, bus.MEM_WEN}, 32'd0);
        chk("stb_wr_a", {22'b0, bus.MEM_A}, 32'd4);
        chk("stb_wr_di", bus.MEM_DI, 32'h1122_AB44);
        chk("stb_busy_e2", {31'b0, BUSY}, 32'd1);
        chk("stb_no_rf", {31'b0, bus.RF_WEN}, 32'd1);
        tick();
        chk("stb_busy_e3", {31'b0, BUSY}, 32'd0);
        chk("stb_ready_e3", {31'b0, bus.REQ_READY}, 32'd1);
        chk("stb_mem4", mem[4], 32'h1122_AB44);
        do_load("ldw_after_stb", 2'b10, 1'b0, 12'h010, 5'd9, 32'h1122_AB44);

        // Halfword store to the upper lane.
        st_word(12'h014, 32'h5566_7788);
        send(1'b1, 2'b01, 1'b0, 12'h016, 32'h1234_BEEF, 5'd0);
        tick(); tick(); tick();
        chk("sth_mem5", mem[5], 32'hBEEF_7788);

        // Misaligned and illegal requests.
        send(1'b0, 2'b01, 1'b0, 12'h001, 32'd0, 5'd7);
        chk("err_h_err", {31'b0, ERR}, 32'd1);
        chk("err_h_ready", {31'b0, bus.REQ_READY}, 32'd1);
        chk("err_h_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        chk("err_h_busy", {31'b0, BUSY}, 32'd0);
        chk("err_h_rf_wen", {31'b0, bus.RF_WEN}, 32'd1);
        tick();
        chk("err_h_pulse", {31'b0, ERR}, 32'd0);
        chk("err_h_csn2", {31'b0, bus.MEM_CSN}, 32'd1);
        chk("err_h_rf_wen2", {31'b0, bus.RF_WEN}, 32'd1);
        send(1'b1, 2'b10, 1'b0, 12'h012, 32'hDEAD_BEEF, 5'd0);
        chk("err_w_err", {31'b0, ERR}, 32'd1);
        chk("err_w_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        tick();
        chk("err_w_mem4", mem[4], 32'h1122_AB44);
        send(1'b0, 2'b11, 1'b0, 12'h010, 32'd0, 5'd2);
        chk("err_sz_err", {31'b0, ERR}, 32'd1);
        chk("err_sz_state", {29'b0, DBG_STATE}, 32'd0);
        tick();

        // Reset during RMW_WAIT of a byte store.
        send(1'b1, 2'b00, 1'b0, 12'h010, 32'h0000_00CD, 5'd0);
        tick();
        chk("rmid_state_wait", {29'b0, DBG_STATE}, 32'd5);
        RST = 1'b1;
        #1;
        chk("rmid_ready_low", {31'b0, bus.REQ_READY}, 32'd0);
        chk("rmid_csn", {31'b0, bus.MEM_CSN}, 32'd1);
        tick();
        RST = 1'b0;
        #1;
        chk("rmid_state", {29'b0, DBG_STATE}, 32'd0);
        chk("rmid_busy", {31'b0, BUSY}, 32'd0);
        chk("rmid_rf_wa", {27'b0, bus.RF_WA}, 32'd0);
        chk("rmid_rf_di", bus.RF_DI, 32'd0);
        chk("rmid_rf_wen", {31'b0, bus.RF_WEN}, 32'd1);
        chk("rmid_mem_a", {22'b0, bus.MEM_A}, 32'd0);
        tick(); tick(); tick();
        chk("rmid_mem4", mem[4], 32'h1122_AB44);

        // Load to r0.
        send(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 5'd0);
        lows = 0;
        wa_low = 5'h1F;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.RF_WEN === 1'b0) begin
                lows++;
                wa_low = bus.RF_WA;
            end
        end
`ifdef MAU_R0_GUARD_EN
        chk("r0_no_write", lows, 32'd0);
`else
        chk("r0_write_once", lows, 32'd1);
        chk("r0_wa", {27'b0, wa_low}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
